screen_fb_arbiter: RTL and testbench
====================================

# screen_fb_arbiter

Owns the 1024x8 SSD1306 framebuffer and shares it between the display refresh reader and two writer clients (A, B). The refresh engine reads pixel bytes through a dedicated, never-stalled read port. Writers reach the memory through a request/grant channel with round-robin arbitration and a hold limit. A built-in clear engine fills the whole buffer with one byte value.

## Interface
- DEPTH, 1024: framebuffer bytes (128x64 / 8); address width fixed at 10
- MAX_HOLD, 64: accepted beats after which a granted writer is preempted if the other writer is requesting; range 1..255

- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- disp_addr_i  in  10  refresh read address (connects to pixel_address_o)
- disp_data_o  out  8  registered read data (connects to pixel_data_i)
- clear_i  in  1  clear request, sampled only in IDLE
- fill_i  in  8  clear fill byte, sampled together with clear_i
- clear_busy_o  out  1  clear engine running
- a_req_i, b_req_i  in  1  ownership request
- a_valid_i, b_valid_i  in  1  write beat valid
- a_addr_i, b_addr_i  in  10  write address
- a_data_i, b_data_i  in  8  write byte
- a_gnt_o, b_gnt_o  out  1  grant; doubles as beat-ready

## Operation
- Memory: simple dual-port, 1 write port, 1 read port. Contents initialise to 0x00 at configuration and are not affected by rst_i.
- Read port: disp_data_o <= mem[disp_addr_i] every cycle, independent of FSM state. Read and write to the same address in the same cycle returns the old data.
- FSM states: IDLE, GNT_A, GNT_B, CLEAR; reset state is IDLE.
- IDLE: priority is clear_i over writers. clear_i=1 latches fill_i, zeroes clr_addr and goes to CLEAR. Otherwise, with only one req high, grant that writer. With both high, grant the writer not granted last. last_grant resets to B, so A wins the first tie.
- GNT_x: x_gnt_o=1.
  - Beat accepted when x_valid_i && x_gnt_o; writes mem[x_addr_i] <= x_data_i.
  - beat_cnt (8 bit) clears on entry and increments per accepted beat, saturating at 255.
  - x_req_i=0 at an edge goes to IDLE.
  - beat_cnt >= MAX_HOLD with the other req=1 at an edge goes to IDLE (preemption). The preempted client keeps its req and is re-granted via round-robin.
  - last_grant <= x on entry.
- CLEAR: one write per cycle, mem[clr_addr] <= fill, clr_addr++. After writing address DEPTH-1, go to IDLE. Writer reqs wait. clear_i is ignored while in CLEAR.
- Clients must not assert valid without req. A beat presented in the cycle req falls is still accepted if gnt is high.
- Addresses are 10 bit and cannot exceed DEPTH-1; no wrap logic is needed.
- rst_i mid-operation: state goes to IDLE, all grants and clear_busy_o drop immediately. A clear in progress is abandoned, leaving memory partially filled. Memory is otherwise preserved.

## Timing
- Reset values: a_gnt_o=0, b_gnt_o=0, clear_busy_o=0, disp_data_o=0x00, beat_cnt=0, last_grant=B.
- Read latency: 1 cycle (address at edge N gives data valid after edge N+1).
- Grant latency: req high sampled at edge N (state IDLE) gives gnt high after edge N.
- Release: req low sampled at edge M gives gnt low after M. State is IDLE for at least 1 cycle, so handover costs 1 idle cycle.
- Write visibility: beat accepted at edge W is readable by a disp read issued at edge W+1 or later.
- Clear: clear_i sampled at edge C; clear_busy_o high from C until the edge that writes address 1023, which is edge C+1024. The arbiter returns to IDLE at that same edge. Total 1024 busy cycles.
- Grants are one-hot; a_gnt_o, b_gnt_o and clear_busy_o are never simultaneously high.

## Test plan
- Single writer: A req, writes 0xAA@5 and 0x55@1023, releases. Then disp reads 5 and 1023 return 0xAA and 0x55 one cycle after the address; b_gnt_o stays 0.
- Tie: A and B req on the same edge after reset. Then A granted first. After A drops, B is granted after exactly 1 IDLE cycle.
- Preemption: MAX_HOLD=4, A streams continuously, B reqs. Then A gnt drops after its 4th beat, and B is granted on the next edge.
- Clear: clear_i=1 with fill_i=0xFF while A also reqs. Then clear wins and clear_busy_o is high for exactly 1024 cycles. Every address reads 0xFF afterwards, and A is granted only after clear completes.
- Same-address collision: write 0x12@7 while disp_addr_i=7 (old 0x00). Then disp_data_o=0x00 that cycle and 0x12 the next.
- Async reset mid-clear at address 300. Then outputs are at reset values immediately without a clock edge. Addresses 0..299 hold fill and 300+ hold prior contents, and a new A req is granted normally.

Source files
------------

// File: rtl/screen_fb_arbiter_if.sv
// Writer-client channel into the framebuffer arbiter: ownership request,
// write beat (valid/addr/data) and the grant that doubles as beat-ready.
interface screen_fb_arbiter_if;
    logic       req;
    logic       valid;
    logic [9:0] addr;
    logic [7:0] data;
    logic       gnt;

    modport master (output req, valid, addr, data, input gnt);
    modport slave  (input req, valid, addr, data, output gnt);
endinterface

// File: rtl/screen_fb_arbiter.sv
// SSD1306 framebuffer owner: free-running refresh read port, round-robin
// arbitration with hold limit for two writers, and a whole-buffer clear engine.
module screen_fb_arbiter #(
    parameter int DEPTH    = 1024,
    parameter int MAX_HOLD = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [9:0]                disp_addr_i,
    output logic [7:0]                disp_data_o,
    input  logic                      clear_i,
    input  logic [7:0]                fill_i,
    output logic                      clear_busy_o,
    screen_fb_arbiter_if.slave        a_if,
    screen_fb_arbiter_if.slave        b_if
);

    localparam logic [7:0] HOLD_LIM  = 8'(MAX_HOLD);
    localparam logic [9:0] LAST_ADDR = 10'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, CLEAR} state_t;

    state_t     state_q, state_d;
    logic       last_a_q, last_a_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [9:0] clr_addr_q, clr_addr_d;
    logic [7:0] fill_q, fill_d;

    logic       accept;
    logic [7:0] beat_next;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;

    logic [7:0] mem [DEPTH] = '{default: 8'h00};

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        if (inc && (v != 8'hFF))
            return v + 8'd1;
        return v;
    endfunction

    // The hold limit counts the beat accepted at this edge, so the grant
    // drops right after the MAX_HOLD-th beat when the other writer waits.
    assign accept    = ((state_q == GNT_A) && a_if.valid) ||
                       ((state_q == GNT_B) && b_if.valid);
    assign beat_next = sat_inc(beat_cnt_q, accept);

    always_comb begin
        state_d    = state_q;
        last_a_d   = last_a_q;
        beat_cnt_d = beat_cnt_q;
        clr_addr_d = clr_addr_q;
        fill_d     = fill_q;
        wr_en      = 1'b0;
        wr_addr    = clr_addr_q;
        wr_data    = fill_q;
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d    = CLEAR;
                    fill_d     = fill_i;
                    clr_addr_d = '0;
                end else if (a_if.req && (!b_if.req || !last_a_q)) begin
                    state_d    = GNT_A;
                    last_a_d   = 1'b1;
                    beat_cnt_d = '0;
                end else if (b_if.req) begin
                    state_d    = GNT_B;
                    last_a_d   = 1'b0;
                    beat_cnt_d = '0;
                end
            end
            GNT_A: begin
                wr_en      = a_if.valid;
                wr_addr    = a_if.addr;
                wr_data    = a_if.data;
                beat_cnt_d = beat_next;
                if (!a_if.req || ((beat_next >= HOLD_LIM) && b_if.req))
                    state_d = IDLE;
            end
            GNT_B: begin
                wr_en      = b_if.valid;
                wr_addr    = b_if.addr;
                wr_data    = b_if.data;
                beat_cnt_d = beat_next;
                if (!b_if.req || ((beat_next >= HOLD_LIM) && a_if.req))
                    state_d = IDLE;
            end
            CLEAR: begin
                wr_en      = 1'b1;
                clr_addr_d = clr_addr_q + 10'd1;
                if (clr_addr_q == LAST_ADDR)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_a_q   <= 1'b0;
            beat_cnt_q <= '0;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            last_a_q   <= last_a_d;
            beat_cnt_q <= beat_cnt_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        fill_q <= fill_d;
    end

    // Write port; gated by FSM state so nothing is written while in reset.
    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read-before-write: a same-address collision returns the old byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            disp_data_o <= '0;
        else
            disp_data_o <= mem[disp_addr_i];
    end

    assign a_if.gnt     = (state_q == GNT_A);
    assign b_if.gnt     = (state_q == GNT_B);
    assign clear_busy_o = (state_q == CLEAR);

endmodule

// File: tb/tb_screen_fb_arbiter.sv
// Self-checking bench for screen_fb_arbiter: directed scenarios plus random
// writer traffic checked against a plain memory/round-robin reference model.
module tb_screen_fb_arbiter;

    localparam int DEPTH    = 1024;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] disp_addr = '0;
    logic [7:0] disp_data;
    logic       clear = 1'b0;
    logic [7:0] fill = '0;
    logic       busy;

    screen_fb_arbiter_if a_if ();
    screen_fb_arbiter_if b_if ();

    screen_fb_arbiter #(.DEPTH(DEPTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .disp_addr_i  (disp_addr),
        .disp_data_o  (disp_data),
        .clear_i      (clear),
        .fill_i       (fill),
        .clear_busy_o (busy),
        .a_if         (a_if),
        .b_if         (b_if)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] ref_mem [DEPTH];
    int         last_win = 1;   // 0 = A, 1 = B; the client granted most recently

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst)
            check("onehot", 32'($countones({a_if.gnt, b_if.gnt, busy}) <= 1), 32'd1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input logic rq, input logic vl,
                         input logic [9:0] ad, input logic [7:0] dt);
        if (c == 0) begin
            a_if.req = rq; a_if.valid = vl; a_if.addr = ad; a_if.data = dt;
        end else begin
            b_if.req = rq; b_if.valid = vl; b_if.addr = ad; b_if.data = dt;
        end
    endtask

    function automatic logic gnt_of(input int c);
        return (c == 0) ? a_if.gnt : b_if.gnt;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        last_win = 1;
    endtask

    task automatic readback_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            disp_addr = 10'(i);
            step();
            check($sformatf("%s[%0d]", tag, i), disp_data, ref_mem[i]);
        end
    endtask

    // Single requester: granted next edge, random beats with gaps.
    task automatic rand_single(input int c);
        int n = 1 + int'($urandom % 6);
        int done = 0;
        logic v;
        logic [9:0] ad;
        logic [7:0] dt;
        drive(c, 1'b1, 1'b0, '0, '0);
        step();
        check("rnd_single_gnt", gnt_of(c), 1);
        check("rnd_single_other", gnt_of(1 - c), 0);
        last_win = c;
        for (int k = 0; k < 40 && done < n; k++) begin
            v  = ($urandom % 4) != 0;
            ad = 10'($urandom % DEPTH);
            dt = 8'($urandom);
            drive(c, 1'b1, v, ad, dt);
            step();
            if (v) begin
                ref_mem[ad] = dt;
                done++;
            end
        end
        drive(c, 1'b0, 1'b0, '0, '0);
        step();
        check("rnd_single_rel", gnt_of(c), 0);
    endtask

    // Both request together: winner is whoever was not granted last;
    // the loser follows after one idle cycle once the winner releases.
    task automatic rand_tie();
        int w = 1 - last_win;
        int l = last_win;
        int n;
        logic [9:0] ad;
        logic [7:0] dt;
        drive(0, 1'b1, 1'b0, '0, '0);
        drive(1, 1'b1, 1'b0, '0, '0);
        step();
        check("rnd_tie_win", gnt_of(w), 1);
        check("rnd_tie_lose", gnt_of(l), 0);
        n = 1 + int'($urandom % 3);
        for (int k = 0; k < n; k++) begin
            ad = 10'($urandom % DEPTH);
            dt = 8'($urandom);
            drive(w, 1'b1, 1'b1, ad, dt);
            step();
            ref_mem[ad] = dt;
        end
        drive(w, 1'b0, 1'b0, '0, '0);
        step();
        check("rnd_tie_idle", 32'({a_if.gnt, b_if.gnt}), 0);
        step();
        check("rnd_tie_next", gnt_of(l), 1);
        n = 1 + int'($urandom % 3);
        for (int k = 0; k < n; k++) begin
            ad = 10'($urandom % DEPTH);
            dt = 8'($urandom);
            drive(l, 1'b1, 1'b1, ad, dt);
            step();
            ref_mem[ad] = dt;
        end
        drive(l, 1'b0, 1'b0, '0, '0);
        step();
        last_win = l;
    endtask

    initial begin
        int busy_cnt;
        int gnt_during;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        do_reset();
        check("rst_a_gnt", a_if.gnt, 0);
        check("rst_b_gnt", b_if.gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_disp", disp_data, 8'h00);

        // Single writer A
        drive(0, 1'b1, 1'b0, '0, '0);
        step();
        check("single_gnt", a_if.gnt, 1);
        drive(0, 1'b1, 1'b1, 10'd5, 8'hAA);
        step();
        check("single_b_idle0", b_if.gnt, 0);
        drive(0, 1'b1, 1'b1, 10'd1023, 8'h55);
        step();
        check("single_b_idle1", b_if.gnt, 0);
        ref_mem[5] = 8'hAA;
        ref_mem[1023] = 8'h55;
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
        check("single_rel", a_if.gnt, 0);
        disp_addr = 10'd5;
        step();
        check("single_rd5", disp_data, 8'hAA);
        disp_addr = 10'd1023;
        step();
        check("single_rd1023", disp_data, 8'h55);

        // Tie after reset: A first, B after one idle cycle
        do_reset();
        drive(0, 1'b1, 1'b0, '0, '0);
        drive(1, 1'b1, 1'b0, '0, '0);
        step();
        check("tie_a_first", a_if.gnt, 1);
        check("tie_b_wait", b_if.gnt, 0);
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
        check("tie_idle_gap", 32'({a_if.gnt, b_if.gnt}), 0);
        step();
        check("tie_b_next", b_if.gnt, 1);
        drive(1, 1'b0, 1'b0, '0, '0);
        step();
        last_win = 1;

        // Preemption after MAX_HOLD beats
        drive(0, 1'b1, 1'b0, '0, '0);
        step();
        check("pre_a_gnt", a_if.gnt, 1);
        drive(1, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < MAX_HOLD; i++) begin
            drive(0, 1'b1, 1'b1, 10'(100 + i), 8'(8'hC0 + i));
            step();
            ref_mem[100 + i] = 8'(8'hC0 + i);
            check($sformatf("pre_a_beat%0d", i), a_if.gnt, (i < MAX_HOLD - 1) ? 1 : 0);
        end
        drive(0, 1'b1, 1'b0, '0, '0);
        check("pre_idle_b", b_if.gnt, 0);
        step();
        check("pre_b_gnt", b_if.gnt, 1);
        check("pre_a_off", a_if.gnt, 0);
        drive(1, 1'b0, 1'b0, '0, '0);
        step();
        step();
        check("pre_a_regnt", a_if.gnt, 1);
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
        last_win = 0;

        // Same-address collision returns old data first
        drive(0, 1'b1, 1'b0, '0, '0);
        step();
        check("col_gnt", a_if.gnt, 1);
        drive(0, 1'b1, 1'b1, 10'd7, 8'h12);
        disp_addr = 10'd7;
        step();
        check("col_old", disp_data, 8'h00);
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
        check("col_new", disp_data, 8'h12);
        ref_mem[7] = 8'h12;

        // Clear wins over a pending writer
        clear = 1'b1;
        fill = 8'hFF;
        drive(0, 1'b1, 1'b0, '0, '0);
        step();
        clear = 1'b0;
        fill = 8'h00;
        busy_cnt = 0;
        gnt_during = 0;
        for (int i = 0; i < 2000 && busy; i++) begin
            busy_cnt++;
            if (a_if.gnt) gnt_during++;
            step();
        end
        check("clr_busy_cycles", busy_cnt, 1024);
        check("clr_no_gnt", gnt_during, 0);
        check("clr_end_idle", a_if.gnt, 0);
        step();
        check("clr_a_after", a_if.gnt, 1);
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
        last_win = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
        readback_all("clr_rd");

        // Async reset mid-clear at address 300
        disp_addr = 10'd1023;
        clear = 1'b1;
        fill = 8'h3C;
        step();
        clear = 1'b0;
        for (int i = 0; i < 300; i++) step();
        check("mid_busy_before", busy, 1);
        check("mid_disp_before", disp_data, 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_a_gnt", a_if.gnt, 0);
        check("mid_rst_b_gnt", b_if.gnt, 0);
        check("mid_rst_disp", disp_data, 8'h00);
        step();
        rst = 1'b0;
        last_win = 1;
        for (int i = 0; i < 300; i++) ref_mem[i] = 8'h3C;
        readback_all("mid_rd");
        drive(0, 1'b1, 1'b0, '0, '0);
        step();
        check("mid_a_gnt", a_if.gnt, 1);
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
        last_win = 0;

        // Random traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            if ($urandom % 3 == 0)
                rand_tie();
            else
                rand_single(int'($urandom % 2));
        end
        readback_all("rnd_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
